// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, synchronizer depth and R/W bit values.
package i2c_pkg;

    localparam int unsigned I2C_SYNC_STAGES = 2;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StReg,
        StRegAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRack
    } i2c_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the clk domain and derives SCL edges and START/STOP conditions.
module i2c_line_sync
    import i2c_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o,
    output logic sda_s_o
);

    logic [I2C_SYNC_STAGES-1:0] scl_sync_q;
    logic [I2C_SYNC_STAGES-1:0] sda_sync_q;
    logic                       scl_hist_q;
    logic                       sda_hist_q;
    logic                       scl_s;
    logic                       sda_s;

    // Idle bus is high, so reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[I2C_SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[I2C_SYNC_STAGES-2:0], sda_i};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
        end
    end

    assign scl_s = scl_sync_q[I2C_SYNC_STAGES-1];
    assign sda_s = sda_sync_q[I2C_SYNC_STAGES-1];

    assign scl_rise_o  = scl_s & ~scl_hist_q;
    assign scl_fall_o  = ~scl_s & scl_hist_q;
    assign start_det_o = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det_o  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
    assign sda_s_o     = sda_s;

endmodule

// File: rtl/i2c_slave.sv
// Oversampled I2C responder with an internal register file, write mirror strobe and host port.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h20,
    parameter int unsigned NREGS      = 32,
    localparam int unsigned AW        = $clog2(NREGS)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          scl_i,
    inout  wire           sda_io,
    input  logic [AW-1:0] host_addr_i,
    output logic [7:0]    host_data_o,
    output logic          wr_valid_o,
    output logic [7:0]    wr_addr_o,
    output logic [7:0]    wr_data_o,
    output logic          busy_o
);

    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic       sda_s;

    i2c_state_t state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic [7:0] tx_q;
    logic [7:0] ptr_q;
    logic       rw_q;
    logic       sda_oe_q;
    logic       busy_q;
    logic       wr_valid_q;
    logic [7:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic [7:0] host_data_q;
    logic [7:0] regs_q [NREGS];
    logic       ptr_in_range;
    logic [7:0] rd_data;

    i2c_line_sync u_line_sync (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .scl_i      (scl_i),
        .sda_i      (sda_io),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_det_o(start_det),
        .stop_det_o (stop_det),
        .sda_s_o    (sda_s)
    );

    assign shift_d      = {shift_q[6:0], sda_s};
    assign ptr_in_range = (32'(ptr_q) < NREGS);

    always_comb begin
        rd_data = 8'hFF;
        if (ptr_in_range) begin
            rd_data = regs_q[ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= '0;
            ptr_q      <= '0;
            rw_q       <= I2C_RW_WRITE;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_valid_q <= 1'b0;
            if (stop_det) begin
                state_q  <= StIdle;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else if (start_det) begin
                state_q   <= StAddr;
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: sda_oe_q <= 1'b0;
                    StAddr: if (scl_rise) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (shift_d[7:1] == SLAVE_ADDR) begin
                                rw_q    <= shift_d[0];
                                busy_q  <= 1'b1;
                                state_q <= StAddrAck;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= StIdle;
                            end
                        end
                    end
                    // First fall after the 8th bit starts the ACK, the next one ends it.
                    StAddrAck: if (scl_fall) begin
                        bit_cnt_q <= '0;
                        if (!sda_oe_q) begin
                            sda_oe_q <= 1'b1;
                        end else if (rw_q == I2C_RW_READ) begin
                            sda_oe_q <= ~rd_data[7];
                            tx_q     <= {rd_data[6:0], 1'b1};
                            state_q  <= StRdata;
                        end else begin
                            sda_oe_q <= 1'b0;
                            state_q  <= StReg;
                        end
                    end
                    StReg: if (scl_rise) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ptr_q   <= shift_d;
                            state_q <= StRegAck;
                        end
                    end
                    StRegAck: if (scl_fall) begin
                        bit_cnt_q <= '0;
                        if (!sda_oe_q) begin
                            sda_oe_q <= 1'b1;
                        end else begin
                            sda_oe_q <= 1'b0;
                            state_q  <= StWdata;
                        end
                    end
                    StWdata: if (scl_rise) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (ptr_in_range) begin
                                regs_q[ptr_q[AW-1:0]] <= shift_d;
                            end
                            wr_valid_q <= 1'b1;
                            wr_addr_q  <= ptr_q;
                            wr_data_q  <= shift_d;
                            state_q    <= StWdataAck;
                        end
                    end
                    StWdataAck: if (scl_fall) begin
                        bit_cnt_q <= '0;
                        if (!sda_oe_q) begin
                            sda_oe_q <= 1'b1;
                        end else begin
                            sda_oe_q <= 1'b0;
                            ptr_q    <= ptr_q + 8'd1;
                            state_q  <= StWdata;
                        end
                    end
                    StRdata: if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_q  <= 1'b0;
                            bit_cnt_q <= '0;
                            state_q   <= StRack;
                        end else begin
                            sda_oe_q  <= ~tx_q[7];
                            tx_q      <= {tx_q[6:0], 1'b1};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                    // bit_cnt_q[0] marks a received ACK awaiting the falling edge.
                    StRack: begin
                        if (scl_rise) begin
                            if (!sda_s) begin
                                ptr_q     <= ptr_q + 8'd1;
                                bit_cnt_q <= 3'd1;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= StIdle;
                            end
                        end else if (scl_fall && bit_cnt_q[0]) begin
                            sda_oe_q  <= ~rd_data[7];
                            tx_q      <= {rd_data[6:0], 1'b1};
                            bit_cnt_q <= '0;
                            state_q   <= StRdata;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            host_data_q <= '0;
        end else begin
            host_data_q <= regs_q[host_addr_i];
        end
    end

    assign sda_io      = sda_oe_q ? 1'b0 : 1'bz;
    assign host_data_o = host_data_q;
    assign wr_valid_o  = wr_valid_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign busy_o      = busy_q;

endmodule
